seg_scan_mux: RTL

- Parametrised time-multiplexed driver for common-anode/cathode multi-digit 7-segment displays.
- Scans NUM_DIGITS digits round-robin at a programmable slot rate.
- Adds per-digit blanking, global PWM brightness, anti-ghosting dead time, output polarity options and a frame-start strobe.
- Sits between the digit-encoding logic (BCD/hex to segment) and the board pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_scan_mux_prescaler.sv | 43 ++++
 rtl/seg_scan_mux.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg_pkg;

    localparam int CLK_HZ_DEFAULT  = 50_000_000;
    localparam int SLOT_HZ_DEFAULT = 120;
    localparam int CLK_DIV_DEFAULT = (CLK_HZ_DEFAULT + SLOT_HZ_DEFAULT / 2) / SLOT_HZ_DEFAULT;
    localparam int DIV_W_DEFAULT   = 20;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int seg_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Map a logical on/off level onto the physical pin level.
    function automatic logic pol_bit(input logic v, input logic act_low);
        return v ^ act_low;
    endfunction

endpackage

// File: rtl/seg_scan_mux_prescaler.sv
// Slot-rate prescaler: counts 0..CLK_DIV-1 while enabled and flags the last count.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int DIV_W   = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [DIV_W-1:0] count,
    output logic             tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (en) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: round-robin digit scan with dead time,
// per-digit blanking, PWM brightness and configurable pin polarity.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SEG_W         = 8,
    parameter int CLK_DIV       = CLK_DIV_DEFAULT,
    parameter int DIV_W         = DIV_W_DEFAULT,
    parameter int DEAD_CYC      = 2,
    parameter int BRIGHT_W      = 4,
    parameter int ANODE_ACT_LOW = 0,
    parameter int SEG_ACT_LOW   = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [NUM_DIGITS*SEG_W-1:0]         seg_in,
    input  logic [NUM_DIGITS-1:0]               digit_blank,
    input  logic [BRIGHT_W-1:0]                 brightness,
    output logic [SEG_W-1:0]                    seg,
    output logic [NUM_DIGITS-1:0]               anode,
    output logic [seg_clog2(NUM_DIGITS)-1:0]    digit_idx,
    output logic                                frame_start
);

    localparam int                   IDX_W     = seg_clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic                 A_LOW     = (ANODE_ACT_LOW != 0);
    localparam logic                 S_LOW     = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = A_LOW ? '1 : '0;
    localparam logic [SEG_W-1:0]     SEG_OFF   = S_LOW ? '1 : '0;

    logic [DIV_W-1:0]      pre_count;
    logic                  pre_tick;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
    logic                  frame_q, frame_d;
    logic                  on_q, on_d;
    logic [IDX_W-1:0]      shown_q, shown_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      seg_q, seg_d;

    logic [SEG_W-1:0]      sel_seg;
    logic                  blank_sel;
    logic                  bright_ok;
    logic                  past_dead;
    logic                  switch_ok;
    logic                  lit;

    seg_prescaler #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (pre_count),
        .tick  (pre_tick)
    );

    always_comb begin
        idx_d   = idx_q;
        pwm_d   = pwm_q;
        frame_d = 1'b0;

        if (en) begin
            pwm_d = pwm_q + BRIGHT_W'(1);
        end

        if (pre_tick) begin
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            frame_d = (idx_q == LAST_IDX);
        end

        sel_seg   = seg_in[int'(idx_q)*SEG_W +: SEG_W];
        blank_sel = digit_blank[int'(idx_q)];
        bright_ok = (pwm_q < brightness) || (&brightness);
        past_dead = (pre_count >= DIV_W'(DEAD_CYC));
        // With no dead time a digit change would swap seg under a lit anode;
        // force one dark cycle whenever the lit digit would change.
        switch_ok = !(on_q && (shown_q != idx_q));

        lit     = en && past_dead && !blank_sel && bright_ok && switch_ok;
        on_d    = lit;
        shown_d = idx_q;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_d[i] = pol_bit(lit && (int'(idx_q) == i), A_LOW);
        end
        for (int j = 0; j < SEG_W; j++) begin
            seg_d[j] = pol_bit(lit && sel_seg[j], S_LOW);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            pwm_q   <= '0;
            frame_q <= 1'b0;
            on_q    <= 1'b0;
            shown_q <= '0;
            anode_q <= ANODE_OFF;
            seg_q   <= SEG_OFF;
        end else begin
            idx_q   <= idx_d;
            pwm_q   <= pwm_d;
            frame_q <= frame_d;
            on_q    <= on_d;
            shown_q <= shown_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign anode       = anode_q;
    assign digit_idx   = idx_q;
    assign frame_start = frame_q;

endmodule
